// File: rtl/riscv_pkg.sv
// Shared encodings for the data-memory path: load/store size codes and
// the responder's sequencing states.
package riscv_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/dmem_load_extend.sv
// Load lane select and sign/zero extension so writeback can use the result as-is.
module dmem_load_extend
  import riscv_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_byte_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [31:0] w_shifted;
  logic [15:0] w_half;

  assign w_shifted = i_word >> {i_byte_off, 3'b000};
  assign w_half    = i_byte_off[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_data = 32'h0;
    case (i_funct3)
      F3_B:    o_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_BU:   o_data = {24'h0, w_shifted[7:0]};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_data = {16'h0, w_half};
      F3_W:    o_data = i_word;
      default: o_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency data-memory responder for the RV32I load/store path.
// Build option DMEM_MISALIGN_TRAP_EN: report misaligned H/HU/W accesses as errors instead of aligning them.
//
// state | meaning
// IDLE  | ready; accept a request
// WAIT  | latency countdown, inputs ignored
// RESP  | one-cycle response pulse
module data_mem_responder
  import riscv_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = $clog2(LATENCY + 1);

  if (LATENCY < 1) begin : g_bad_latency
    $error("data_mem_responder: LATENCY must be at least 1");
  end

  dmem_state_e   r_state;
  logic [CW-1:0] r_cnt;
  logic          r_we;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [2:0]    r_funct3;
  logic          r_ready;
  logic          r_rsp_valid;
  logic          r_rsp_err;
  logic [31:0]   r_rsp_rdata;
  logic [31:0]   r_mem [DEPTH_WORDS];

  // With LATENCY=1 the access happens on the accept edge, so use the live request.
  logic        w_use_req, w_fire, w_we, w_err, w_range_err, w_f3_err;
  logic [31:0] w_addr, w_wdata, w_load, w_lanes;
  logic [2:0]  w_f3;
  logic [1:0]  w_off;
  logic [3:0]  w_be;
  logic [AW-1:0] w_idx;

  assign w_use_req = (r_state == IDLE);
  assign w_we      = w_use_req ? req_we     : r_we;
  assign w_addr    = w_use_req ? req_addr   : r_addr;
  assign w_wdata   = w_use_req ? req_wdata  : r_wdata;
  assign w_f3      = w_use_req ? req_funct3 : r_funct3;
  assign w_fire    = (r_state == IDLE && req_valid && LATENCY == 1) ||
                     (r_state == WAIT && r_cnt <= CW'(1));
  assign w_idx     = w_addr[AW+1:2];

  assign w_range_err = ({2'b00, w_addr[31:2]} >= 32'(DEPTH_WORDS));

  always_comb begin
    w_f3_err = 1'b1;
    case (w_f3)
      F3_B, F3_H, F3_W: w_f3_err = 1'b0;
      F3_BU, F3_HU:     w_f3_err = w_we;
      default:          w_f3_err = 1'b1;
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic w_misalign;
  assign w_misalign = ((w_f3 == F3_H || w_f3 == F3_HU) && w_addr[0]) ||
                      (w_f3 == F3_W && w_addr[1:0] != 2'b00);
  assign w_off      = w_addr[1:0];
  assign w_err      = w_range_err | w_f3_err | w_misalign;
`else
  always_comb begin
    w_off = w_addr[1:0];
    if (w_f3 == F3_H || w_f3 == F3_HU) w_off[0] = 1'b0;
    else if (w_f3 == F3_W)             w_off    = 2'b00;
  end
  assign w_err = w_range_err | w_f3_err;
`endif

  always_comb begin
    w_be    = 4'b0000;
    w_lanes = w_wdata;
    case (w_f3)
      F3_B: begin
        w_be    = 4'b0001 << w_off;
        w_lanes = {4{w_wdata[7:0]}};
      end
      F3_H: begin
        w_be    = w_off[1] ? 4'b1100 : 4'b0011;
        w_lanes = {2{w_wdata[15:0]}};
      end
      F3_W:    w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  dmem_load_extend u_load_extend (
    .i_word     (r_mem[w_idx]),
    .i_byte_off (w_off),
    .i_funct3   (w_f3),
    .o_data     (w_load)
  );

  // Array contents survive reset; a write only lands on the edge entering RESP.
  always_ff @(posedge clk) begin
    if (!reset && w_fire && w_we && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_lanes[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_addr      <= 32'h0;
      r_wdata     <= 32'h0;
      r_funct3    <= 3'b000;
      r_ready     <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'h0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we     <= req_we;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_funct3 <= req_funct3;
            r_cnt    <= CW'(LATENCY - 1);
            r_ready  <= 1'b0;
            r_state  <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - CW'(1);
        end
        RESP: begin
          r_state     <= IDLE;
          r_ready     <= 1'b1;
          r_rsp_valid <= 1'b0;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= 32'h0;
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
      endcase
      if (w_fire) begin
        r_state     <= RESP;
        r_cnt       <= '0;
        r_ready     <= 1'b0;
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= w_err;
        r_rsp_rdata <= (w_err || w_we) ? 32'h0 : w_load;
      end
    end
  end

  assign req_ready = r_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder at LATENCY=2, DEPTH_WORDS=1024.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  int checks   = 0;
  int failures = 0;

  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [2:0] f3,
                        input logic [31:0] exp_d, input logic exp_e);
    int  n;
    bit  got;
    @(negedge clk);
    chk({tag, "_ready_pre"}, {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_funct3 = f3;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_funct3 = 3'b000;
    n = 0; got = 1'b0;
    while (!got && n < 10) begin
      @(negedge clk);
      n++;
      if (rsp_valid) got = 1'b1;
    end
    chk({tag, "_latency"}, 32'(n), 32'd2);
    chk({tag, "_rdata"}, rsp_rdata, exp_d);
    chk({tag, "_err"}, {31'h0, rsp_err}, {31'h0, exp_e});
    @(negedge clk);
    chk({tag, "_ready_post"}, {31'h0, req_ready}, 32'h1);
    chk({tag, "_valid_post"}, {31'h0, rsp_valid}, 32'h0);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; req_funct3 = 3'b000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_err",   {31'h0, rsp_err},   32'h0);
    chk("rst_rdata", rsp_rdata,          32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'h0, req_ready}, 32'h1);

    // Known-zero words used by the range and reset cases.
    do_req("init0",  1'b1, 32'h0,  32'h0, 3'b010, 32'h0, 1'b0);
    do_req("init20", 1'b1, 32'h20, 32'h0, 3'b010, 32'h0, 1'b0);

    do_req("sw10",   1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0,        1'b0);
    do_req("lw10",   1'b0, 32'h10, 32'h0,        3'b010, 32'hDEADBEEF, 1'b0);

    do_req("sb13",   1'b1, 32'h13, 32'h00000080, 3'b000, 32'h0,        1'b0);
    do_req("lb13",   1'b0, 32'h13, 32'h0,        3'b000, 32'hFFFFFF80, 1'b0);
    do_req("lbu13",  1'b0, 32'h13, 32'h0,        3'b100, 32'h00000080, 1'b0);
    do_req("lw10b",  1'b0, 32'h10, 32'h0,        3'b010, 32'h80ADBEEF, 1'b0);

    do_req("sh12",   1'b1, 32'h12, 32'h00001234, 3'b001, 32'h0,        1'b0);
    do_req("lh12",   1'b0, 32'h12, 32'h0,        3'b001, 32'h00001234, 1'b0);
    do_req("lw10c",  1'b0, 32'h10, 32'h0,        3'b010, 32'h1234BEEF, 1'b0);
    do_req("lhu10",  1'b0, 32'h10, 32'h0,        3'b101, 32'h0000BEEF, 1'b0);
    do_req("lh10",   1'b0, 32'h10, 32'h0,        3'b001, 32'hFFFFBEEF, 1'b0);

`ifdef DMEM_MISALIGN_TRAP_EN
    do_req("lw11",   1'b0, 32'h11, 32'h0,        3'b010, 32'h0,        1'b1);
`else
    do_req("lw11",   1'b0, 32'h11, 32'h0,        3'b010, 32'h1234BEEF, 1'b0);
`endif

    do_req("sw1000", 1'b1, 32'h1000, 32'h1,      3'b010, 32'h0,        1'b1);
    do_req("lw0",    1'b0, 32'h0,    32'h0,      3'b010, 32'h0,        1'b0);
    do_req("ld_f3_3",  1'b0, 32'h10, 32'h0,      3'b011, 32'h0,        1'b1);
    do_req("st_f3_bu", 1'b1, 32'h10, 32'hFF,     3'b100, 32'h0,        1'b1);
    do_req("lw10d",  1'b0, 32'h10, 32'h0,        3'b010, 32'h1234BEEF, 1'b0);

    // Store aborted by reset in the cycle after accept.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h55; req_funct3 = 3'b010;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    begin
      logic seen;
      seen = 1'b0;
      repeat (4) begin
        @(negedge clk);
        if (rsp_valid) seen = 1'b1;
      end
      chk("rst_abort_no_valid", {31'h0, seen}, 32'h0);
    end
    chk("rst_abort_ready", {31'h0, req_ready}, 32'h1);
    do_req("lw20", 1'b0, 32'h20, 32'h0, 3'b010, 32'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
